// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the divided-clock controller: FSM state
// encoding, default parameter values and a small state decode helper.
package clk_ctrl_pkg;

   // Controller states; encoding is fixed so external observers can decode it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

   // Default half-period counter width and reset half-period.
   localparam int unsigned CNT_W_DEF      = 32'd8;
   localparam int unsigned RESET_HALF_DEF = 32'd2;

   // True when the controller is producing (or finishing) a clock.
   function automatic logic state_busy(input state_e st);
      logic busy_v;
      case (st)
         IDLE:    busy_v = 1'b0;
         RUN:     busy_v = 1'b1;
         STOP:    busy_v = 1'b1;
         default: busy_v = 1'b0;
      endcase
      return busy_v;
   endfunction

endpackage

// File: rtl/clk_half_counter.sv
// Half-period counter for clk_div_ctrl: owns cnt and half_q, toggles the
// divided clock at the end of each half period and produces tick on rise.
// Optional build macro: CLK_DIV_CTRL_PERIOD_CNT_EN adds a 16-bit wrapping
// count of rising edges on output `periods`.
module clk_half_counter
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned RESET_HALF = RESET_HALF_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             at_end,
   output logic             clk_out,
   output logic             tick
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]      periods
`endif
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             at_end_s;
   logic             rise_s;

   // Last count of a half period; half_q is never zero so the subtraction cannot wrap.
   assign at_end_s = (cnt_q == (half_q - CNT_W'(1)));
   assign rise_s   = run & at_end_s & ~clk_out_q;

   // Next-state for counter, divided clock, tick and half-period register.
   always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      half_d    = half_q;
      tick_d    = rise_s;
      if (run) begin
         if (at_end_s) begin
            cnt_d     = CNT_W'(0);
            clk_out_d = ~clk_out_q;
         end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            clk_out_d = clk_out_q;
         end
      end else begin
         // Parked: clock held low and counter cleared so RUN restarts cleanly.
         cnt_d     = CNT_W'(0);
         clk_out_d = 1'b0;
      end
      // A new ratio only lands on a boundary edge, so the old ratio finishes the period.
      if (load) begin
         half_d = load_val;
      end else begin
         half_d = half_q;
      end
   end

   // State registers for the counter datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= CNT_W'(0);
         half_q    <= CNT_W'(RESET_HALF);
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
      end
   end

   assign at_end  = at_end_s;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   logic [15:0] periods_q, periods_d;

   // Rising-edge counter; updates on the same edge as tick so it reads consistently with it.
   always_comb begin
      if (rise_s) begin
         periods_d = periods_q + 16'd1;
      end else begin
         periods_d = periods_q;
      end
   end

   // Period counter register; cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         periods_q <= 16'd0;
      end else begin
         periods_q <= periods_d;
      end
   end

   assign periods = periods_q;
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop sequencing FSM plus the ratio-change
// request/acknowledge handshake around clk_half_counter.
// Optional build macro: CLK_DIV_CTRL_PERIOD_CNT_EN exposes `periods`.
module clk_div_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned RESET_HALF = RESET_HALF_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_req,
   input  logic [CNT_W-1:0] div_val,
   output logic             div_ack,
   output logic             div_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
   ,
   output logic [15:0]      periods
`endif
);

   state_e           state_q, state_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] pend_val_q, pend_val_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic             run_s;
   logic             load_s;
   logic [CNT_W-1:0] load_val_s;
   logic             at_end_s;
   logic             clk_out_s;
   logic             fall_edge_s;
   logic             go_idle_s;
   logic             capture_s;

   clk_half_counter #(
      .CNT_W      (CNT_W),
      .RESET_HALF (RESET_HALF)
   ) u_half_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run_s),
      .load     (load_s),
      .load_val (load_val_s),
      .at_end   (at_end_s),
      .clk_out  (clk_out_s),
      .tick     (tick)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      ,
      .periods  (periods)
`endif
   );

   // Run/stop sequencing: decides whether the counter runs this edge and the next state.
   always_comb begin
      state_d = state_q;
      run_s   = 1'b0;
      case (state_q)
         IDLE: begin
            run_s = 1'b0;
            if (en) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (en) begin
               run_s   = 1'b1;
               state_d = RUN;
            end else if (!clk_out_s) begin
               // Low phase may be cut short; the clock is already low.
               run_s   = 1'b0;
               state_d = IDLE;
            end else begin
               // High phase must complete; if it ends on this very edge go straight to IDLE.
               run_s = 1'b1;
               if (at_end_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // en is ignored here: the stop always completes.
            run_s = 1'b1;
            if (at_end_s) begin
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            run_s   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign fall_edge_s = run_s & at_end_s & clk_out_s;
   assign go_idle_s   = (state_q != IDLE) & (state_d == IDLE);
   assign capture_s   = div_req & ~pend_q & ~ack_q;

   // Ratio-change handshake: capture, reject zero, and apply on a period boundary.
   always_comb begin
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      load_s     = 1'b0;
      load_val_s = pend_val_q;
      if (pend_q) begin
         if (fall_edge_s || go_idle_s || (state_q == IDLE)) begin
            load_s     = 1'b1;
            load_val_s = pend_val_q;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end else if (capture_s) begin
         if (div_val == CNT_W'(0)) begin
            ack_d = 1'b1;
            err_d = 1'b1;
         end else if (state_q == IDLE) begin
            // Nothing is running, so the new ratio can be taken immediately.
            load_s     = 1'b1;
            load_val_s = div_val;
            ack_d      = 1'b1;
         end else begin
            pend_d     = 1'b1;
            pend_val_d = div_val;
         end
      end else begin
         pend_d = pend_q;
      end
      busy_d = state_busy(state_d);
   end

   // Controller state, handshake state and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         pend_val_q <= CNT_W'(0);
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign div_ack = ack_q;
   assign div_err = err_q;
   assign clk_out = clk_out_s;
   assign busy    = busy_q;

endmodule
